// File: rtl/ifetch_unit.sv
// Instruction fetch stage: a two-entry tagged buffer (current + sequential prefetch)
// in front of a single-outstanding valid/ready instruction-memory bus.
module ifetch_unit #(
    parameter int unsigned PREFETCH = 1,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        invalidate,
    output logic [31:0] insn,
    output logic        insn_valid,
    output logic        fetch_misaligned,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t      state;
    logic [31:0] cur_addr, cur_data;
    logic [31:0] pf_addr, pf_data;
    logic [31:0] out_addr;
    logic        cur_vld, pf_vld, drop;

    logic        misaligned, bypass, cur_hit, pf_hit, any_hit;
    logic        install, install_cur, install_pf, promote, pf_need;
    logic [31:0] next_addr;

    // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
    always_comb begin
        misaligned  = (pc[1:0] != 2'b00);
        bypass      = (state == RSP) && imem_rvalid && !drop && (out_addr == pc);
        cur_hit     = cur_vld && (cur_addr == pc);
        pf_hit      = pf_vld && (pf_addr == pc);
        any_hit     = bypass || cur_hit || pf_hit;
        next_addr   = cur_addr + 32'd4;

        insn        = NOP;
        insn_valid  = 1'b1;
        if (misaligned) begin
            insn = NOP;
        end else if (bypass) begin
            insn = imem_rdata;
        end else if (cur_hit) begin
            insn = cur_data;
        end else if (pf_hit) begin
            insn = pf_data;
        end else begin
            insn_valid = 1'b0;
        end
        fetch_misaligned = misaligned;

        // A response landing alongside invalidate, or after one, is never written back.
        install     = (state == RSP) && imem_rvalid && !drop && !invalidate;
        install_cur = install && (out_addr == pc);
        install_pf  = install && (out_addr != pc);
        promote     = pf_hit && !cur_hit;
        pf_need     = (PREFETCH != 0) && cur_hit && !(pf_vld && (pf_addr == next_addr));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            out_addr  <= '0;
            drop      <= 1'b0;
        end else begin
            if ((state == RSP) && imem_rvalid) begin
                drop <= 1'b0;
            end else if (invalidate && (state != IDLE)) begin
                drop <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!misaligned && !any_hit) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= {pc[31:2], 2'b00};
                    end else if (pf_need) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= next_addr;
                    end
                end
                REQ: begin
                    // Address stays put until accepted, even if pc has moved on.
                    if (imem_gnt) begin
                        state    <= RSP;
                        imem_req <= 1'b0;
                        out_addr <= imem_addr;
                    end
                end
                RSP: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || invalidate) begin
            cur_vld <= 1'b0;
            pf_vld  <= 1'b0;
        end else begin
            if (install_cur || promote) begin
                cur_vld <= 1'b1;
            end
            if (install_pf) begin
                pf_vld <= 1'b1;
            end else if (promote) begin
                pf_vld <= 1'b0;
            end
        end
    end

    // NOTE: tag and data storage is not reset; the valid bits alone decide whether it is ever read.
    always_ff @(posedge clk) begin
        if (install_cur) begin
            cur_addr <= pc;
            cur_data <= imem_rdata;
        end else if (promote) begin
            cur_addr <= pf_addr;
            cur_data <= pf_data;
        end
        if (install_pf) begin
            pf_addr <= out_addr;
            pf_data <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!insn_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
